mmu_translate: RTL
==================

Name: mmu_translate

Overview:
- Registered, handshaked virtual-to-physical translation unit. Successor to the combinational segment mapper.
- Adds a parametrised fully-associative TLB with a software write port, ASID matching and a flush.
- Produces per-request exception codes.
- Sits between the IF/MEM request stage and the cache/bus interface. One request per cycle, 1-cycle latency.

Parameters:
- TLB_ENTRIES, 8, number of TLB entries (power of two, 2..32)
- PAGE_BITS, 12, page offset width. VPN/PFN width = 32 - PAGE_BITS
- ASID_W, 8, address-space identifier width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  translation request valid
- req_ready  out  1  unit can accept request this cycle
- req_vaddr  in  32  virtual address
- req_write  in  1  request is a store
- req_user  in  1  request issued in user mode
- cur_asid  in  ASID_W  current ASID, sampled with request
- k0_uncached  in  1  kseg0 cacheability override (1 = uncached)
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_paddr  out  32  physical address
- resp_uncached  out  1  access is uncached
- resp_exc  out  3  0 none, 1 address error, 2 TLB miss, 3 TLB invalid, 4 TLB modified
- tlb_we  in  1  TLB entry write strobe
- tlb_index  in  log2(TLB_ENTRIES)  entry to write
- tlb_vpn  in  32-PAGE_BITS  entry VPN
- tlb_asid  in  ASID_W  entry ASID
- tlb_pfn  in  32-PAGE_BITS  entry PFN
- tlb_flags  in  4  {G, V, D, C}: global, valid, dirty, uncached
- tlb_flush  in  1  invalidate all entries

Behaviour:
- Reset: resp_valid=0, resp_paddr=0, resp_uncached=0, resp_exc=0. All entry-present bits cleared. req_ready=1 the cycle after reset deasserts.
- Handshake:
  - req_ready = !resp_valid || resp_ready (combinational).
  - Request accepted when req_valid && req_ready. Response appears the next cycle.
  - Response holds stable while resp_valid && !resp_ready.
  - resp_valid drops after the handshake if no new request is accepted.
- Segment decode on vaddr[31:29]:
  - 100 (kseg0): paddr = {3'b0, vaddr[28:0]}, uncached = k0_uncached.
  - 101 (kseg1): paddr = {3'b0, vaddr[28:0]}, uncached = 1.
  - 0xx (useg), 110/111 (kseg2/3): TLB lookup.
- User check: req_user && vaddr[31] gives exc=1, paddr=0, uncached=0. No lookup. Takes priority over all TLB exceptions.
- TLB lookup:
  - Hit when entry present && vpn == vaddr[31:PAGE_BITS] && (G || asid == cur_asid).
  - Multiple hits: lowest index wins.
  - Miss gives exc=2. Hit with V=0 gives exc=3. Hit with V=1, D=0, req_write=1 gives exc=4.
  - Otherwise paddr = {pfn, vaddr[PAGE_BITS-1:0]}, uncached = C.
  - On any exception, paddr=0.
- TLB write:
  - tlb_we writes the entry and sets its present bit. Takes effect the following cycle.
  - A lookup accepted in the same cycle sees old contents.
- tlb_flush clears all present bits next cycle. With tlb_we in the same cycle, flush applies first, then the write, so the indexed entry ends up present.
- Flush/write never alter a response already held in the output register.
- Reset mid-stall drops the pending response. The TLB is cleared.

Test Plan:
- Reset, then req 0x8000_1234 user=0, k0_uncached=0 -> next cycle resp_valid=1, paddr 0x0000_1234, uncached=0, exc=0. Repeat with 0xA000_1234 -> uncached=1.
- req 0x8000_0000 user=1 -> exc=1, paddr=0. req 0x0040_0010 with empty TLB -> exc=2.
- Write idx3 vpn=0x00400 asid=5 pfn=0x12345 flags G0V1D0C0; cur_asid=5:
  - load 0x0040_0ABC -> paddr 0x1234_5ABC, exc=0.
  - store -> exc=4.
  - cur_asid=6 -> exc=2.
  - rewrite with G=1 -> hit with asid 6.
- Same-cycle tlb_we and request to the written VPN -> exc=2 (old contents); next-cycle request -> hit. Flush+write idx1 same cycle -> idx3 gone, idx1 present.
- Back-to-back requests 4 cycles with resp_ready=0 on cycle 2: req_ready=0 while stalled, held response unchanged, no request lost or duplicated, throughput 1/cycle otherwise.
- Duplicate VPN in idx2 and idx5 with different PFNs -> idx2 PFN returned. Assert rst during a stall -> resp_valid=0 next cycle, subsequent lookup misses.

Source files
------------

// File: rtl/mmu_translate.sv
// rtl/mmu_translate.sv - registered virtual-to-physical translation with fully-associative TLB
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_vaddr, req_write, req_user, cur_asid, k0_uncached
//   resp_valid/resp_ready       response handshake; resp_paddr, resp_uncached, resp_exc
//                               resp_exc: 0 none, 1 address error, 2 TLB miss, 3 TLB invalid, 4 TLB modified
//   tlb_we, tlb_index, tlb_vpn, tlb_asid, tlb_pfn, tlb_flags {G,V,D,C}   TLB entry write port
//   tlb_flush                   invalidate all entries
module mmu_translate #(
  parameter int TLB_ENTRIES = 8,
  parameter int PAGE_BITS   = 12,
  parameter int ASID_W      = 8,
  localparam int IDX_W      = $clog2(TLB_ENTRIES),
  localparam int VPN_W      = 32 - PAGE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_vaddr,
  input  logic              req_write,
  input  logic              req_user,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic              k0_uncached,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_paddr,
  output logic              resp_uncached,
  output logic [2:0]        resp_exc,
  input  logic              tlb_we,
  input  logic [IDX_W-1:0]  tlb_index,
  input  logic [VPN_W-1:0]  tlb_vpn,
  input  logic [ASID_W-1:0] tlb_asid,
  input  logic [VPN_W-1:0]  tlb_pfn,
  input  logic [3:0]        tlb_flags,
  input  logic              tlb_flush
);

  localparam logic [2:0] EXC_NONE  = 3'd0;
  localparam logic [2:0] EXC_ADDR  = 3'd1;
  localparam logic [2:0] EXC_MISS  = 3'd2;
  localparam logic [2:0] EXC_INVAL = 3'd3;
  localparam logic [2:0] EXC_MOD   = 3'd4;

  // flag bit positions within an entry
  localparam int F_G = 3;
  localparam int F_V = 2;
  localparam int F_D = 1;
  localparam int F_C = 0;

  logic [TLB_ENTRIES-1:0] present_q, present_d;
  logic [VPN_W-1:0]       vpn_q   [TLB_ENTRIES];
  logic [VPN_W-1:0]       vpn_d   [TLB_ENTRIES];
  logic [ASID_W-1:0]      asid_q  [TLB_ENTRIES];
  logic [ASID_W-1:0]      asid_d  [TLB_ENTRIES];
  logic [VPN_W-1:0]       pfn_q   [TLB_ENTRIES];
  logic [VPN_W-1:0]       pfn_d   [TLB_ENTRIES];
  logic [3:0]             flags_q [TLB_ENTRIES];
  logic [3:0]             flags_d [TLB_ENTRIES];

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_paddr_q, resp_paddr_d;
  logic        resp_uncached_q, resp_uncached_d;
  logic [2:0]  resp_exc_q, resp_exc_d;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [3:0]       hit_flags;
  logic [VPN_W-1:0] hit_pfn;
  logic [31:0]      xl_paddr;
  logic             xl_uncached;
  logic [2:0]       xl_exc;
  logic             accept;

  assign req_ready     = !resp_valid_q || resp_ready;
  assign accept        = req_valid && req_ready;
  assign resp_valid    = resp_valid_q;
  assign resp_paddr    = resp_paddr_q;
  assign resp_uncached = resp_uncached_q;
  assign resp_exc      = resp_exc_q;

  // Associative search against the registered TLB state, so a write in the
  // same cycle is not yet visible. Ascending scan with a found flag makes the
  // lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (!hit && present_q[i] && vpn_q[i] == req_vaddr[31:PAGE_BITS] &&
          (flags_q[i][F_G] || asid_q[i] == cur_asid)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    hit_flags = flags_q[hit_idx];
    hit_pfn   = pfn_q[hit_idx];
  end

  always_comb begin
    xl_paddr    = 32'd0;
    xl_uncached = 1'b0;
    xl_exc      = EXC_NONE;
    if (req_user && req_vaddr[31]) begin
      xl_exc = EXC_ADDR;
    end else if (req_vaddr[31:29] == 3'b100) begin
      xl_paddr    = {3'b000, req_vaddr[28:0]};
      xl_uncached = k0_uncached;
    end else if (req_vaddr[31:29] == 3'b101) begin
      xl_paddr    = {3'b000, req_vaddr[28:0]};
      xl_uncached = 1'b1;
    end else if (!hit) begin
      xl_exc = EXC_MISS;
    end else if (!hit_flags[F_V]) begin
      xl_exc = EXC_INVAL;
    end else if (req_write && !hit_flags[F_D]) begin
      xl_exc = EXC_MOD;
    end else begin
      xl_paddr    = {hit_pfn, req_vaddr[PAGE_BITS-1:0]};
      xl_uncached = hit_flags[F_C];
    end
  end

  // Output register: load on accept, drop valid after a consumed response,
  // otherwise hold (stall).
  always_comb begin
    resp_valid_d    = resp_valid_q;
    resp_paddr_d    = resp_paddr_q;
    resp_uncached_d = resp_uncached_q;
    resp_exc_d      = resp_exc_q;
    if (accept) begin
      resp_valid_d    = 1'b1;
      resp_paddr_d    = xl_paddr;
      resp_uncached_d = xl_uncached;
      resp_exc_d      = xl_exc;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Flush first, then the write, so a combined flush+write leaves the
  // written entry present.
  always_comb begin
    present_d = present_q;
    vpn_d     = vpn_q;
    asid_d    = asid_q;
    pfn_d     = pfn_q;
    flags_d   = flags_q;
    if (tlb_flush) present_d = '0;
    if (tlb_we) begin
      present_d[tlb_index] = 1'b1;
      vpn_d[tlb_index]     = tlb_vpn;
      asid_d[tlb_index]    = tlb_asid;
      pfn_d[tlb_index]     = tlb_pfn;
      flags_d[tlb_index]   = tlb_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      present_q       <= '0;
      resp_valid_q    <= 1'b0;
      resp_paddr_q    <= 32'd0;
      resp_uncached_q <= 1'b0;
      resp_exc_q      <= EXC_NONE;
    end else begin
      present_q       <= present_d;
      resp_valid_q    <= resp_valid_d;
      resp_paddr_q    <= resp_paddr_d;
      resp_uncached_q <= resp_uncached_d;
      resp_exc_q      <= resp_exc_d;
    end
  end

  // Entry payload is qualified by present_q, so it needs no reset.
  always_ff @(posedge clk) begin
    vpn_q   <= vpn_d;
    asid_q  <= asid_d;
    pfn_q   <= pfn_d;
    flags_q <= flags_d;
  end

endmodule
